gray_counter_display: RTL and testbench

GRAY_COUNTER_DISPLAY -- requirements
Module: gray_counter_display

---
 rtl/gray_pkg.sv | 25 ++
 rtl/seg7_hex_decoder.sv | 11 +
 rtl/gray_counter_display.sv | 102 ++++++++++
 tb/tb_gray_counter_display.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - Gray code helpers and active-low hex segment table
package gray_pkg;

    // Segment patterns are {g,f,e,d,c,b,a}, active low, indexed by hex digit.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

    function automatic logic [15:0] bin2gray(input logic [15:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [15:0] gray2bin(input logic [15:0] g);
        logic [15:0] b;
        b[15] = g[15];
        for (int i = 14; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// rtl/seg7_hex_decoder.sv - combinational hex digit to active-low 7-segment decode
module seg7_hex_decoder
    import gray_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/gray_counter_display.sv
// rtl/gray_counter_display.sv - up/down Gray counter with multiplexed hex display
module gray_counter_display
    import gray_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int SCAN_DIV = 1000,
    localparam int DIGITS  = (WIDTH + 3) / 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              up,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_value,
    output logic [WIDTH-1:0]  gray_out,
    output logic [WIDTH-1:0]  bin_out,
    output logic              wrap,
    output logic [6:0]        seg_out,
    output logic [DIGITS-1:0] dig_sel
);

    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DIG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PAD_W  = DIGITS * 4;

    logic [WIDTH-1:0]  next_bin;
    logic [WIDTH-1:0]  next_gray;
    logic              next_wrap;
    logic [SCAN_W-1:0] scan_cnt;
    logic              scan_tc;
    logic [DIG_W-1:0]  dig_idx;
    logic [DIG_W-1:0]  dig_next;
    logic [PAD_W-1:0]  gray_pad;
    logic [3:0]        nibble;
    logic [6:0]        seg_next;

    always_comb begin
        next_bin  = bin_out;
        next_wrap = 1'b0;
        if (load) begin
            next_bin = load_value;
        end else if (en) begin
            if (up) begin
                next_bin  = bin_out + 1'b1;
                next_wrap = &bin_out;
            end else begin
                next_bin  = bin_out - 1'b1;
                next_wrap = ~|bin_out;
            end
        end
    end

    assign next_gray = WIDTH'(bin2gray(16'(next_bin)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_out  <= '0;
            gray_out <= '0;
            wrap     <= 1'b0;
        end else begin
            bin_out  <= next_bin;
            gray_out <= next_gray;
            wrap     <= next_wrap;
        end
    end

    assign scan_tc  = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
    assign dig_next = !scan_tc ? dig_idx :
                      (dig_idx == DIG_W'(DIGITS - 1)) ? '0 : dig_idx + 1'b1;

    // The mux reads the registered Gray value, so the display lags a count by one clock.
    assign gray_pad = PAD_W'(gray_out);

    always_comb begin
        nibble = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (dig_next == DIG_W'(i)) begin
                nibble = gray_pad[i*4 +: 4];
            end
        end
    end

    seg7_hex_decoder u_dec (
        .hex (nibble),
        .seg (seg_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            dig_idx  <= '0;
            dig_sel  <= ~DIGITS'(1);
            seg_out  <= 7'b1000000;
        end else begin
            scan_cnt <= scan_tc ? '0 : scan_cnt + 1'b1;
            dig_idx  <= dig_next;
            dig_sel  <= ~(DIGITS'(1) << dig_next);
            seg_out  <= seg_next;
        end
    end

endmodule

// File: tb/tb_gray_counter_display.sv
// tb/tb_gray_counter_display.sv - scoreboard bench for gray_counter_display
module tb_gray_counter_display;

    localparam logic [6:0] SEGT [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    localparam logic [3:0] GSEQ [16] = '{
        4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
        4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000
    };

    typedef struct {
        bit         c4;
        logic [3:0] bin;
        logic [3:0] gray;
        logic       wrap;
        logic [6:0] seg4;
        bit         hg;
        logic [3:0] hgray;
        bit         en_only;
        logic [3:0] pgray;
        bit         c8;
        logic [7:0] bin8;
        logic [7:0] gray8;
        logic [6:0] seg8;
        logic [1:0] dig8;
    } exp_t;

    logic       clk = 1'b0;
    logic       clk_run = 1'b1;
    logic       rst_n = 1'b0;
    logic       en4 = 0, up4 = 0, load4 = 0;
    logic [3:0] lv4 = '0;
    logic [3:0] gray4, bin4;
    logic       wrap4;
    logic [6:0] seg4;
    logic [0:0] dig4;
    logic       en8 = 0, up8 = 0, load8 = 0;
    logic [7:0] lv8 = '0;
    logic [7:0] gray8, bin8;
    logic       wrap8;
    logic [6:0] seg8;
    logic [1:0] dig8;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t q[$];
    logic [3:0] m_bin = '0;

    always #5 if (clk_run) clk = ~clk;

    gray_counter_display #(.WIDTH(4), .SCAN_DIV(1)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en4), .up(up4), .load(load4), .load_value(lv4),
        .gray_out(gray4), .bin_out(bin4), .wrap(wrap4), .seg_out(seg4), .dig_sel(dig4)
    );

    gray_counter_display #(.WIDTH(8), .SCAN_DIV(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .en(en8), .up(up8), .load(load8), .load_value(lv8),
        .gray_out(gray8), .bin_out(bin8), .wrap(wrap8), .seg_out(seg8), .dig_sel(dig8)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] g2b(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        b[2] = b[3] ^ g[2];
        b[1] = b[2] ^ g[1];
        b[0] = b[1] ^ g[0];
        return b;
    endfunction

    function automatic int popcnt(input logic [3:0] v);
        return int'(v[0]) + int'(v[1]) + int'(v[2]) + int'(v[3]);
    endfunction

    // Monitor: one scoreboard entry per clock edge that the driver announced
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            if (e.c4) begin
                chk("bin4", bin4, e.bin);
                chk("gray4", gray4, e.gray);
                chk("wrap4", wrap4, e.wrap);
                chk("seg4", seg4, e.seg4);
                chk("dig4", dig4, 1'b0);
                chk("gray2bin4", g2b(gray4), bin4);
                if (e.hg) chk("gray4_vector", gray4, e.hgray);
                if (e.en_only) chk("hamming4", popcnt(gray4 ^ e.pgray), 1);
            end
            if (e.c8) begin
                chk("bin8", bin8, e.bin8);
                chk("gray8", gray8, e.gray8);
                chk("seg8", seg8, e.seg8);
                chk("dig8", dig8, e.dig8);
            end
        end
    end

    task automatic step4(input logic e, input logic u, input logic l, input logic [3:0] lv,
                         input bit hg, input logic [3:0] hgv);
        exp_t x;
        logic [3:0] nb;
        logic w;
        @(negedge clk);
        en4 = e; up4 = u; load4 = l; lv4 = lv;
        nb = m_bin;
        w  = 1'b0;
        if (l) begin
            nb = lv;
        end else if (e) begin
            if (u) begin
                nb = m_bin + 4'd1;
                w  = (m_bin == 4'hF);
            end else begin
                nb = m_bin - 4'd1;
                w  = (m_bin == 4'h0);
            end
        end
        x = '{default: 0};
        x.c4      = 1;
        x.bin     = nb;
        x.gray    = nb ^ (nb >> 1);
        x.wrap    = w;
        x.seg4    = SEGT[m_bin ^ (m_bin >> 1)];
        x.hg      = hg;
        x.hgray   = hgv;
        x.en_only = e && !l;
        x.pgray   = m_bin ^ (m_bin >> 1);
        q.push_back(x);
        m_bin = nb;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_bin4"}, bin4, 4'h0);
        chk({tag, "_gray4"}, gray4, 4'h0);
        chk({tag, "_wrap4"}, wrap4, 1'b0);
        chk({tag, "_seg4"}, seg4, 7'b1000000);
        chk({tag, "_dig4"}, dig4, 1'b0);
        chk({tag, "_bin8"}, bin8, 8'h00);
        chk({tag, "_gray8"}, gray8, 8'h00);
        chk({tag, "_seg8"}, seg8, 7'b1000000);
        chk({tag, "_dig8"}, dig8, 2'b10);
    endtask

    initial begin
        exp_t x;
        repeat (2) @(negedge clk);
        check_reset_values("rst_hold");

        // WIDTH=8 display: load 0xA5 on the first edge after release, then watch the scan
        @(negedge clk);
        rst_n = 1'b1; load8 = 1'b1; lv8 = 8'hA5;
        x = '{default: 0};
        x.c8 = 1; x.bin8 = 8'hA5; x.gray8 = 8'hF7; x.seg8 = 7'b1000000; x.dig8 = 2'b10;
        q.push_back(x);
        for (int k = 2; k <= 16; k++) begin
            @(negedge clk);
            load8 = 1'b0;
            x = '{default: 0};
            x.c8 = 1; x.bin8 = 8'hA5; x.gray8 = 8'hF7;
            if (((k / 4) % 2) == 1) begin
                x.dig8 = 2'b01; x.seg8 = 7'b0001110;
            end else begin
                x.dig8 = 2'b10; x.seg8 = 7'b1111000;
            end
            q.push_back(x);
        end

        // Full up-count sequence including the rollover
        for (int i = 0; i < 16; i++) step4(1, 1, 0, 4'h0, 1, GSEQ[i]);

        step4(0, 0, 1, 4'b1110, 1, 4'b1001);
        step4(1, 1, 1, 4'b1010, 1, 4'b1111);

        // Async reset with clock stopped and a load pending
        @(negedge clk);
        en4 = 0; load4 = 1; lv4 = 4'b0111;
        clk_run = 1'b0;
        #3 rst_n = 1'b0;
        #1 check_reset_values("async_rst");
        load4 = 1'b0;
        #2 rst_n = 1'b1;
        m_bin = '0;
        #2 clk_run = 1'b1;

        step4(1, 0, 0, 4'h0, 1, 4'b1000);
        step4(0, 0, 0, 4'h0, 1, 4'b1000);
        step4(1, 1, 0, 4'h0, 1, 4'b0000);

        for (int i = 0; i < 500; i++) begin
            step4(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)), 0, 4'h0);
        end

        @(negedge clk);
        en4 = 0; load4 = 0;
        repeat (2) @(negedge clk);
        if (q.size() != 0) chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
